id_stage: RTL
=============

Name: id_stage

Overview:
- Instruction-decode stage of the 5-stage MIPS32 pipeline. It consumes the registered instruction from the fetch stage and sits between fetch and execute.
- Decodes the instruction, reads the 32x32 register file, and resolves beq/j in ID with one architectural delay slot.
- Detects load-use and branch-operand hazards and drives stall, jump_cs and Next_pc back to fetch.
- Registers all EX-stage operands and controls in an internal ID/EX pipeline register.

Parameters:
- PC_W, 6, width of the word-indexed PC and of Next_pc.
- NREG, 32, number of architectural registers. Register 0 is hardwired to zero.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instruction  in  32  instruction word from fetch
- pc_in  in  PC_W  PC of instruction
- wb_we  in  1  writeback enable
- wb_addr  in  5  writeback register
- wb_data  in  32  writeback data
- mem_reg_write  in  1  MEM-stage instruction writes a register
- mem_rd  in  5  MEM-stage destination register
- stall  out  1  hold PC and instruction in fetch (combinational)
- jump_cs  out  1  redirect PC this cycle (combinational)
- Next_pc  out  PC_W  redirect target (combinational)
- ex_valid  out  1  ID/EX holds a real instruction
- ex_rs_data, ex_rt_data  out  32  register operands
- ex_imm  out  32  sign-extended imm16
- ex_rs, ex_rt, ex_rd  out  5  source registers; ex_rd is the destination (rd for R-type, rt for I-type)
- ex_alu_op  out  3  0 add, 1 sub, 2 and, 3 or, 4 slt
- ex_alu_src  out  1  1 selects ex_imm
- ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg  out  1  EX/MEM/WB controls
- ex_illegal  out  1  unsupported opcode/funct was decoded

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All ex_* outputs are 0; ex_rd=0 means a NOP bubble.
  - All registers are cleared.
  - stall=0, jump_cs=0, Next_pc=0 (pc_in does not matter).
- Supported instructions:
  - R-type (op 0x00) with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
  - addi 0x08, lw 0x23, sw 0x2B, beq 0x04, j 0x02.
  - An all-zero instruction is a NOP: ex_valid=1, all write/mem controls 0, ex_illegal=0.
  - Any other encoding loads ID/EX with all controls 0, ex_valid=1, ex_illegal=1.
- Register file:
  - Two asynchronous read ports and one synchronous write port on the clk rising edge.
  - Writes to register 0 are ignored; reads of register 0 return 0.
  - Write-first bypass: if wb_we and wb_addr equals a read address (nonzero), the read returns wb_data in the same cycle.
- ID/EX register:
  - Loads every cycle; latency is 1 cycle from instruction to the ex_* outputs.
  - When stall=1 it loads a bubble: all ex_* outputs 0, including ex_valid.
- Hazard rules (stall=1 when any holds; rs/rt here are the current instruction's sources, used only if nonzero and actually read):
  - Load-use: ex_mem_read=1 and ex_rd matches rs or rt.
  - Branch operand from EX: instruction is beq, ex_reg_write=1 and ex_rd matches rs or rt.
  - Branch operand from MEM: instruction is beq, mem_reg_write=1 and mem_rd matches rs or rt.
- Redirect:
  - j: jump_cs=1, Next_pc=instruction[PC_W-1:0].
  - beq with rs_data==rt_data: jump_cs=1, Next_pc=pc_in+1+imm[PC_W-1:0], wrapping modulo 2^PC_W.
  - Not-taken beq and all other instructions: jump_cs=0, Next_pc=pc_in+1.
  - The instruction in the following slot always executes (delay slot); this stage never flushes.
- Simultaneous stall and branch/jump: stall takes priority and jump_cs=0. The decision is re-evaluated when the hazard clears.
- Reset mid-operation: state is cleared immediately; no partial writes are retained.

Decomposition:
- Package mips_pkg holds:
  - opcode and funct localparams;
  - the alu_op encoding;
  - a typedef for the ID/EX control bundle.
- Sub-module reg_file holds the 32x32 array with the write-first bypass and r0 handling.
- Decode, hazard logic and the ID/EX register remain in id_stage.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> all ex_* outputs, stall and jump_cs are 0 immediately; reads of r1..r31 return 0 after release.
- Bypass: wb_we=1, wb_addr=5, wb_data=0x1234 with instruction add $3,$5,$0 in the same cycle -> next cycle ex_rs_data=0x1234, ex_alu_op=0, ex_reg_write=1, ex_rd=3.
- r0 write: wb_we=1, wb_addr=0, wb_data=0xFFFFFFFF, then or $1,$0,$0 -> ex_rs_data=0.
- Load-use, first part: lw $2,0($1) then add $4,$2,$2 -> stall=1 for exactly one cycle and the following ID/EX contents are all zero.
- Load-use, second part: after that bubble, the add is issued with ex_rd=4.
- beq taken and j:
  - beq $1,$1,+3 at pc_in=62 -> jump_cs=1, Next_pc=2 (wrap).
  - j 0x15 -> jump_cs=1, Next_pc=21.
- Stall/branch priority: beq $2,$0 while ex_reg_write=1 and ex_rd=2 -> stall=1, jump_cs=0. After ex_rd changes, jump_cs reflects the comparison.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS32 encodings and the ID/EX control bundle.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;

    typedef struct packed {
        logic    valid;
        logic    illegal;
        alu_op_e alu_op;
        logic    alu_src;
        logic    mem_read;
        logic    mem_write;
        logic    reg_write;
        logic    mem_to_reg;
    } ctrl_t;

endpackage

// File: rtl/reg_file.sv
// 32x32 register file: two async read ports, one sync write port, write-first bypass, r0 tied to zero.
module reg_file #(
    parameter int unsigned NREG = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_a_i,
    input  logic [4:0]  raddr_b_i,
    output logic [31:0] rdata_a_o,
    output logic [31:0] rdata_b_o
);

    logic [31:0] regs_q [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        if (raddr_a_i == 5'd0)                       rdata_a_o = '0;
        else if (we_i && (waddr_i == raddr_a_i))     rdata_a_o = wdata_i;
        else                                         rdata_a_o = regs_q[raddr_a_i];

        if (raddr_b_i == 5'd0)                       rdata_b_o = '0;
        else if (we_i && (waddr_i == raddr_b_i))     rdata_b_o = wdata_i;
        else                                         rdata_b_o = regs_q[raddr_b_i];
    end

endmodule

// File: rtl/id_stage.sv
// MIPS32 decode stage: decode, register read, beq/j resolution, hazard stall and ID/EX register.
module id_stage #(
    parameter int unsigned PC_W = 6,
    parameter int unsigned NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     instruction,
    input  logic [PC_W-1:0] pc_in,
    input  logic            wb_we,
    input  logic [4:0]      wb_addr,
    input  logic [31:0]     wb_data,
    input  logic            mem_reg_write,
    input  logic [4:0]      mem_rd,
    output logic            stall,
    output logic            jump_cs,
    output logic [PC_W-1:0] Next_pc,
    output logic            ex_valid,
    output logic [31:0]     ex_rs_data,
    output logic [31:0]     ex_rt_data,
    output logic [31:0]     ex_imm,
    output logic [4:0]      ex_rs,
    output logic [4:0]      ex_rt,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_alu_op,
    output logic            ex_alu_src,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_reg_write,
    output logic            ex_mem_to_reg,
    output logic            ex_illegal
);
    import mips_pkg::*;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm;
    logic [31:0] rs_data, rt_data;

    assign op    = instruction[31:26];
    assign rs    = instruction[25:21];
    assign rt    = instruction[20:16];
    assign rd    = instruction[15:11];
    assign funct = instruction[5:0];
    assign imm   = {{16{instruction[15]}}, instruction[15:0]};

    reg_file #(.NREG(NREG)) u_rf (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_i      (wb_we),
        .waddr_i   (wb_addr),
        .wdata_i   (wb_data),
        .raddr_a_i (rs),
        .raddr_b_i (rt),
        .rdata_a_o (rs_data),
        .rdata_b_o (rt_data)
    );

    ctrl_t      ctrl;
    logic [4:0] dst;
    logic       use_rs, use_rt, is_beq, is_j;

    always_comb begin
        ctrl       = '0;
        ctrl.valid = 1'b1;
        dst        = '0;
        use_rs     = 1'b0;
        use_rt     = 1'b0;
        is_beq     = 1'b0;
        is_j       = 1'b0;
        case (op)
            OP_RTYPE: begin
                if (instruction != '0) begin
                    use_rs         = 1'b1;
                    use_rt         = 1'b1;
                    dst            = rd;
                    ctrl.reg_write = 1'b1;
                    case (funct)
                        FN_ADD:  ctrl.alu_op = ALU_ADD;
                        FN_SUB:  ctrl.alu_op = ALU_SUB;
                        FN_AND:  ctrl.alu_op = ALU_AND;
                        FN_OR:   ctrl.alu_op = ALU_OR;
                        FN_SLT:  ctrl.alu_op = ALU_SLT;
                        default: begin
                            ctrl         = '0;
                            ctrl.valid   = 1'b1;
                            ctrl.illegal = 1'b1;
                            dst          = '0;
                            use_rs       = 1'b0;
                            use_rt       = 1'b0;
                        end
                    endcase
                end
            end
            OP_ADDI: begin
                use_rs = 1'b1; dst = rt;
                ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1;
            end
            OP_LW: begin
                use_rs = 1'b1; dst = rt;
                ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1;
                ctrl.mem_read  = 1'b1; ctrl.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                use_rs = 1'b1; use_rt = 1'b1; dst = rt;
                ctrl.alu_src = 1'b1; ctrl.mem_write = 1'b1;
            end
            OP_BEQ: begin
                use_rs = 1'b1; use_rt = 1'b1; dst = rt;
                is_beq = 1'b1; ctrl.alu_op = ALU_SUB;
            end
            OP_J:    is_j = 1'b1;
            default: ctrl.illegal = 1'b1;
        endcase
    end

    ctrl_t       ctrl_q;
    logic [31:0] rs_data_q, rt_data_q, imm_q;
    logic [4:0]  rs_q, rt_q, rd_q;

    logic hit_ex, hit_mem, stall_c;

    // Only sources the instruction really reads can create a hazard; r0 never does.
    assign hit_ex  = (rd_q != 5'd0) && ((use_rs && (rs == rd_q)) || (use_rt && (rt == rd_q)));
    assign hit_mem = (mem_rd != 5'd0) && ((use_rs && (rs == mem_rd)) || (use_rt && (rt == mem_rd)));
    assign stall_c = (ctrl_q.mem_read && hit_ex)
                   || (is_beq && ((ctrl_q.reg_write && hit_ex) || (mem_reg_write && hit_mem)));

    logic [PC_W-1:0] target;
    assign target  = is_j ? instruction[PC_W-1:0] : pc_in + PC_W'(1) + imm[PC_W-1:0];
    assign stall   = rst_n && stall_c;
    assign jump_cs = rst_n && !stall_c && (is_j || (is_beq && (rs_data == rt_data)));
    assign Next_pc = !rst_n ? '0 : (jump_cs ? target : pc_in + PC_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
        end else if (stall_c) begin
            ctrl_q    <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
        end else begin
            ctrl_q    <= ctrl;
            rs_data_q <= rs_data;
            rt_data_q <= rt_data;
            imm_q     <= imm;
            rs_q      <= rs;
            rt_q      <= rt;
            rd_q      <= dst;
        end
    end

    assign ex_valid      = ctrl_q.valid;
    assign ex_illegal    = ctrl_q.illegal;
    assign ex_alu_op     = ctrl_q.alu_op;
    assign ex_alu_src    = ctrl_q.alu_src;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign ex_rs_data    = rs_data_q;
    assign ex_rt_data    = rt_data_q;
    assign ex_imm        = imm_q;
    assign ex_rs         = rs_q;
    assign ex_rt         = rt_q;
    assign ex_rd         = rd_q;

endmodule
